// File: rtl/rs_select_station.sv
// Reservation station: wakes sources from writeback tags and issues the oldest ready uop per FU port.
// A uop with both sources ready issues one cycle after dispatch. RS_DISP_BYPASS_EN lets same-cycle writebacks wake a dispatching uop.
module rs_select_station #(
    parameter int RS_ENTRIES = 8,
    parameter int NUM_FUS    = 4,
    parameter int NUM_WB     = 2,
    parameter int TAG_W      = 6,
    parameter int PAYLOAD_W  = 32,
    localparam int FU_W      = (NUM_FUS > 1) ? $clog2(NUM_FUS) : 1,
    localparam int OCC_W     = $clog2(RS_ENTRIES + 1)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           disp_valid,
    output logic                           disp_ready,
    input  logic [FU_W-1:0]                disp_fu,
    input  logic [TAG_W-1:0]               disp_src1_tag,
    input  logic                           disp_src1_rdy,
    input  logic [TAG_W-1:0]               disp_src2_tag,
    input  logic                           disp_src2_rdy,
    input  logic [PAYLOAD_W-1:0]           disp_payload,
    input  logic [NUM_WB-1:0]              wb_valid,
    input  logic [NUM_WB*TAG_W-1:0]        wb_tag,
    output logic [NUM_FUS-1:0]             iss_valid,
    input  logic [NUM_FUS-1:0]             iss_ready,
    output logic [NUM_FUS*PAYLOAD_W-1:0]   iss_payload,
    input  logic                           flush,
    output logic [OCC_W-1:0]               occupancy
);

    logic [RS_ENTRIES-1:0] r_vld;
    logic [RS_ENTRIES-1:0] r_s1_rdy;
    logic [RS_ENTRIES-1:0] r_s2_rdy;
    logic [FU_W-1:0]       r_fu      [RS_ENTRIES];
    logic [TAG_W-1:0]      r_s1_tag  [RS_ENTRIES];
    logic [TAG_W-1:0]      r_s2_tag  [RS_ENTRIES];
    logic [PAYLOAD_W-1:0]  r_payload [RS_ENTRIES];
    // r_older[i][j] set means entry j was dispatched before entry i
    logic [RS_ENTRIES-1:0] r_older   [RS_ENTRIES];
    logic [OCC_W-1:0]      r_occ;

    logic [RS_ENTRIES-1:0] w_elig;
    logic [RS_ENTRIES-1:0] w_cand    [NUM_FUS];
    logic [RS_ENTRIES-1:0] w_sel     [NUM_FUS];
    logic [RS_ENTRIES-1:0] w_iss_clr;
    logic [RS_ENTRIES-1:0] w_alloc_oh;
    logic [RS_ENTRIES-1:0] w_wake1;
    logic [RS_ENTRIES-1:0] w_wake2;
    logic [NUM_FUS-1:0]    w_iss_vld;
    logic [OCC_W-1:0]      w_num_iss;
    logic                  w_accept;
    logic                  w_byp1;
    logic                  w_byp2;

    assign disp_ready = (r_occ < OCC_W'(RS_ENTRIES));
    assign w_accept   = disp_valid && disp_ready && !flush;
    assign occupancy  = r_occ;
    assign w_elig     = r_vld & r_s1_rdy & r_s2_rdy;
    assign w_alloc_oh = ~r_vld & (r_vld + RS_ENTRIES'(1));
    assign iss_valid  = w_iss_vld;

    always_comb begin
        for (int f = 0; f < NUM_FUS; f++) begin
            for (int i = 0; i < RS_ENTRIES; i++) begin
                w_cand[f][i] = w_elig[i] && (r_fu[i] == FU_W'(f));
            end
        end
    end

    // An entry wins when no other candidate for the same FU is older than it
    always_comb begin
        for (int f = 0; f < NUM_FUS; f++) begin
            for (int i = 0; i < RS_ENTRIES; i++) begin
                w_sel[f][i] = w_cand[f][i] && ((w_cand[f] & r_older[i]) == '0);
            end
        end
    end

    always_comb begin
        w_iss_vld   = '0;
        iss_payload = '0;
        w_iss_clr   = '0;
        w_num_iss   = '0;
        for (int f = 0; f < NUM_FUS; f++) begin
            w_iss_vld[f] = |w_sel[f];
            for (int i = 0; i < RS_ENTRIES; i++) begin
                if (w_sel[f][i]) begin
                    iss_payload[f*PAYLOAD_W +: PAYLOAD_W] = r_payload[i];
                end
            end
            if (w_iss_vld[f] && iss_ready[f]) begin
                w_iss_clr = w_iss_clr | w_sel[f];
                w_num_iss = w_num_iss + OCC_W'(1);
            end
        end
    end

    always_comb begin
        w_wake1 = '0;
        w_wake2 = '0;
        for (int i = 0; i < RS_ENTRIES; i++) begin
            for (int k = 0; k < NUM_WB; k++) begin
                if (wb_valid[k] && (wb_tag[k*TAG_W +: TAG_W] == r_s1_tag[i])) begin
                    w_wake1[i] = 1'b1;
                end
                if (wb_valid[k] && (wb_tag[k*TAG_W +: TAG_W] == r_s2_tag[i])) begin
                    w_wake2[i] = 1'b1;
                end
            end
        end
    end

`ifdef RS_DISP_BYPASS_EN
    always_comb begin
        w_byp1 = 1'b0;
        w_byp2 = 1'b0;
        for (int k = 0; k < NUM_WB; k++) begin
            if (wb_valid[k] && (wb_tag[k*TAG_W +: TAG_W] == disp_src1_tag)) begin
                w_byp1 = 1'b1;
            end
            if (wb_valid[k] && (wb_tag[k*TAG_W +: TAG_W] == disp_src2_tag)) begin
                w_byp2 = 1'b1;
            end
        end
    end
`else
    assign w_byp1 = 1'b0;
    assign w_byp2 = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld    <= '0;
            r_s1_rdy <= '0;
            r_s2_rdy <= '0;
            r_occ    <= '0;
            for (int i = 0; i < RS_ENTRIES; i++) begin
                r_older[i]   <= '0;
                r_fu[i]      <= '0;
                r_s1_tag[i]  <= '0;
                r_s2_tag[i]  <= '0;
                r_payload[i] <= '0;
            end
        end else if (flush) begin
            r_vld <= '0;
            r_occ <= '0;
        end else begin
            r_vld <= (r_vld & ~w_iss_clr) | (w_accept ? w_alloc_oh : '0);
            r_occ <= r_occ + OCC_W'(w_accept) - w_num_iss;
            for (int i = 0; i < RS_ENTRIES; i++) begin
                if (w_accept && w_alloc_oh[i]) begin
                    r_fu[i]      <= disp_fu;
                    r_s1_tag[i]  <= disp_src1_tag;
                    r_s2_tag[i]  <= disp_src2_tag;
                    r_s1_rdy[i]  <= disp_src1_rdy | w_byp1;
                    r_s2_rdy[i]  <= disp_src2_rdy | w_byp2;
                    r_payload[i] <= disp_payload;
                    r_older[i]   <= r_vld;
                end else begin
                    if (w_wake1[i]) r_s1_rdy[i] <= 1'b1;
                    if (w_wake2[i]) r_s2_rdy[i] <= 1'b1;
                    // A newly allocated entry is younger than everyone, so clear its column
                    if (w_accept) r_older[i] <= r_older[i] & ~w_alloc_oh;
                end
            end
        end
    end

endmodule

// File: tb/tb_rs_select_station.sv
// Scoreboard bench for rs_select_station: expected issues are queued at dispatch and matched per FU on issue.
module tb_rs_select_station;

    logic        clk = 1'b0;
    logic        rst;
    logic        disp_valid;
    logic        disp_ready;
    logic [1:0]  disp_fu;
    logic [5:0]  disp_src1_tag;
    logic        disp_src1_rdy;
    logic [5:0]  disp_src2_tag;
    logic        disp_src2_rdy;
    logic [31:0] disp_payload;
    logic [1:0]  wb_valid;
    logic [11:0] wb_tag;
    logic [3:0]  iss_valid;
    logic [3:0]  iss_ready;
    logic [127:0] iss_payload;
    logic        flush;
    logic [3:0]  occupancy;

    typedef struct packed {
        logic [1:0]  fu;
        logic [31:0] pl;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_bad = 0;
    logic exp_byp;
    int   mon_idx;
    logic mon_found;

    rs_select_station dut (
        .clk(clk), .rst(rst),
        .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_fu(disp_fu),
        .disp_src1_tag(disp_src1_tag), .disp_src1_rdy(disp_src1_rdy),
        .disp_src2_tag(disp_src2_tag), .disp_src2_rdy(disp_src2_rdy),
        .disp_payload(disp_payload), .wb_valid(wb_valid), .wb_tag(wb_tag),
        .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_payload(iss_payload),
        .flush(flush), .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic [1:0] fu, input logic [5:0] t1, input logic r1,
                       input logic [5:0] t2, input logic r2, input logic [31:0] pl,
                       input logic push);
        exp_t e;
        disp_valid    = 1'b1;
        disp_fu       = fu;
        disp_src1_tag = t1;
        disp_src1_rdy = r1;
        disp_src2_tag = t2;
        disp_src2_rdy = r2;
        disp_payload  = pl;
        if (push) begin
            e.fu = fu;
            e.pl = pl;
            sb.push_back(e);
        end
        tick();
        disp_valid = 1'b0;
    endtask

    task automatic drain();
        for (int c = 0; c < 40 && sb.size() != 0; c++) tick();
    endtask

    // Every accepted issue must be the oldest outstanding scoreboard entry for that FU
    always @(negedge clk) begin
        if (!rst) begin
            for (int f = 0; f < 4; f++) begin
                if (iss_valid[f] && iss_ready[f]) begin
                    mon_found = 1'b0;
                    mon_idx   = 0;
                    for (int i = 0; i < sb.size(); i++) begin
                        if (!mon_found && sb[i].fu == 2'(f)) begin
                            mon_found = 1'b1;
                            mon_idx   = i;
                        end
                    end
                    chk("iss_sb_hit", 32'(mon_found), 32'd1);
                    if (mon_found) begin
                        chk("iss_payload", iss_payload[f*32 +: 32], sb[mon_idx].pl);
                        sb.delete(mon_idx);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout sb_left=%0d", sb.size());
        $fatal(1);
    end

    initial begin
`ifdef RS_DISP_BYPASS_EN
        exp_byp = 1'b1;
`else
        exp_byp = 1'b0;
`endif
        rst = 1'b1; disp_valid = 1'b0; disp_fu = '0; disp_src1_tag = '0; disp_src1_rdy = 1'b0;
        disp_src2_tag = '0; disp_src2_rdy = 1'b0; disp_payload = '0; wb_valid = '0; wb_tag = '0;
        iss_ready = '0; flush = 1'b0;
        #12;
        chk("rst_occ", 32'(occupancy), 32'd0);
        chk("rst_disp_ready", 32'(disp_ready), 32'd1);
        chk("rst_iss_valid", 32'(iss_valid), 32'd0);
        chk("rst_iss_payload", 32'(|iss_payload), 32'd0);
        tick();
        rst = 1'b0;
        tick();

        // Fill with unready uops
        for (int i = 0; i < 8; i++) drv(2'd0, 6'(10 + i), 1'b0, 6'(40 + i), 1'b0, 32'h100 + i, 1'b0);
        @(negedge clk);
        chk("fill_occ", 32'(occupancy), 32'd8);
        chk("fill_disp_ready", 32'(disp_ready), 32'd0);
        chk("fill_iss_valid", 32'(iss_valid), 32'd0);
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        @(negedge clk);
        chk("flush1_occ", 32'(occupancy), 32'd0);

        // Age order on one FU
        tick();
        iss_ready = 4'b0010;
        drv(2'd1, 6'd0, 1'b1, 6'd0, 1'b1, 32'hA000_000A, 1'b1);
        drv(2'd1, 6'd0, 1'b1, 6'd0, 1'b1, 32'hB000_000B, 1'b1);
        @(negedge clk);
        chk("age_occ_mid", 32'(occupancy), 32'd1);
        @(negedge clk);
        chk("age_occ_end", 32'(occupancy), 32'd0);

        // Wakeup via slot 0, no issue before the broadcast edge
        tick();
        iss_ready = 4'b0100;
        drv(2'd2, 6'd5, 1'b0, 6'd0, 1'b1, 32'hC000_000C, 1'b1);
        @(negedge clk);
        chk("wake_pre_valid", 32'(iss_valid[2]), 32'd0);
        chk("wake_pre_payload", iss_payload[64 +: 32], 32'd0);
        tick();
        wb_valid = 2'b01;
        wb_tag   = {6'd9, 6'd5};
        @(negedge clk);
        chk("wake_edge_valid", 32'(iss_valid[2]), 32'd0);
        tick();
        wb_valid = 2'b00;
        @(negedge clk);
        chk("wake_post_valid", 32'(iss_valid[2]), 32'd1);
        @(negedge clk);
        chk("wake_occ", 32'(occupancy), 32'd0);

        // One tag on slot 1 wakes both sources
        tick();
        iss_ready = 4'b1000;
        drv(2'd3, 6'd7, 1'b0, 6'd7, 1'b0, 32'hD000_000D, 1'b1);
        wb_valid = 2'b10;
        wb_tag   = {6'd7, 6'd0};
        tick();
        wb_valid = 2'b00;
        @(negedge clk);
        chk("dual_wake_valid", 32'(iss_valid[3]), 32'd1);
        @(negedge clk);
        chk("dual_wake_occ", 32'(occupancy), 32'd0);

        // Parallel issue on all four FUs
        tick();
        iss_ready = 4'b0000;
        for (int f = 0; f < 4; f++) drv(2'(f), 6'd0, 1'b1, 6'd0, 1'b1, 32'h400 + f, 1'b1);
        @(negedge clk);
        chk("par_occ_pre", 32'(occupancy), 32'd4);
        chk("par_iss_valid", 32'(iss_valid), 32'hF);
        tick();
        iss_ready = 4'b1111;
        @(negedge clk);
        @(negedge clk);
        chk("par_occ_post", 32'(occupancy), 32'd0);

        // Full station with a simultaneous issue, then reuse of the freed slot
        tick();
        iss_ready = 4'b0000;
        for (int i = 0; i < 8; i++) drv(2'd0, 6'd0, 1'b1, 6'd0, 1'b1, 32'h500 + i, 1'b1);
        @(negedge clk);
        chk("full_occ", 32'(occupancy), 32'd8);
        chk("full_disp_ready", 32'(disp_ready), 32'd0);
        tick();
        iss_ready = 4'b0001;
        disp_valid = 1'b1; disp_fu = 2'd0; disp_src1_rdy = 1'b1; disp_src2_rdy = 1'b1;
        disp_payload = 32'hDEAD_0000;
        @(negedge clk);
        chk("full_iss_disp_ready", 32'(disp_ready), 32'd0);
        tick();
        iss_ready = 4'b0000;
        disp_valid = 1'b0;
        @(negedge clk);
        chk("full_after_occ", 32'(occupancy), 32'd7);
        chk("full_after_disp_ready", 32'(disp_ready), 32'd1);
        tick();
        drv(2'd0, 6'd0, 1'b1, 6'd0, 1'b1, 32'h5FF, 1'b1);
        iss_ready = 4'b0001;
        drain();
        @(negedge clk);
        chk("reuse_sb_left", 32'(sb.size()), 32'd0);
        chk("reuse_occ", 32'(occupancy), 32'd0);

        // Flush with five entries and a dispatch in the same cycle
        tick();
        iss_ready = 4'b0000;
        for (int i = 0; i < 5; i++) drv(2'd0, 6'(30 + i), 1'b0, 6'(50 + i), 1'b0, 32'h600 + i, 1'b0);
        flush = 1'b1;
        disp_valid = 1'b1; disp_fu = 2'd1; disp_src1_rdy = 1'b1; disp_src2_rdy = 1'b1;
        disp_payload = 32'hBAD0_0001;
        tick();
        flush = 1'b0;
        disp_valid = 1'b0;
        @(negedge clk);
        chk("flush_occ", 32'(occupancy), 32'd0);
        chk("flush_iss_valid", 32'(iss_valid), 32'd0);
        tick();
        iss_ready = 4'b1111;
        tick();
        tick();

        // Dispatch racing a writeback of its own source tag
        iss_ready = 4'b0100;
        wb_valid = 2'b01;
        wb_tag   = {6'd0, 6'd20};
        drv(2'd2, 6'd20, 1'b0, 6'd0, 1'b1, 32'hE000_000E, 1'b1);
        wb_valid = 2'b00;
        @(negedge clk);
        chk("byp_iss_valid", 32'(iss_valid[2]), 32'(exp_byp));
        tick();
        wb_valid = 2'b01;
        tick();
        wb_valid = 2'b00;
        drain();
        @(negedge clk);
        chk("byp_sb_left", 32'(sb.size()), 32'd0);

        // Reset mid-operation
        tick();
        iss_ready = 4'b0000;
        drv(2'd0, 6'd0, 1'b1, 6'd0, 1'b1, 32'hF000_000F, 1'b0);
        @(negedge clk);
        chk("midrst_occ_pre", 32'(occupancy), 32'd1);
        chk("midrst_valid_pre", 32'(iss_valid), 32'h1);
        rst = 1'b1;
        #1;
        chk("midrst_occ", 32'(occupancy), 32'd0);
        chk("midrst_valid", 32'(iss_valid), 32'd0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_disp_ready", 32'(disp_ready), 32'd1);

        chk("final_sb_left", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
